// File: rtl/prog_ctrl_if.sv
// Button inputs and clock-manager programming outputs of prog_ctrl.
interface prog_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic [2:0] prog_in;
    logic       update;
    logic [2:0] sel;
    logic       pending;

    modport master (
        output btn_up, btn_down, btn_load,
        input  prog_in, update, sel, pending
    );

    modport slave (
        input  btn_up, btn_down, btn_load,
        output prog_in, update, sel, pending
    );
endinterface

// File: rtl/prog_ctrl.sv
// Button front end for the clock manager: synchronize and debounce up/down/load,
// keep a pending 3-bit selection and issue a prog_in/update strobe on load.
module prog_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned UPDATE_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    prog_ctrl_if.slave bus
);
    localparam int unsigned NBTN  = 3;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PW    = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    UPD_LAST = PW'(UPDATE_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_MAX  = '1;

    typedef enum logic {
        IDLE   = 1'b0,
        STROBE = 1'b1
    } state_t;

    // Bit 0 = up, bit 1 = down, bit 2 = load.
    logic [NBTN-1:0]  raw;
    logic [NBTN-1:0]  s1;
    logic [NBTN-1:0]  s2;
    logic [NBTN-1:0]  stable;
    logic [NBTN-1:0]  stable_d;
    logic [NBTN-1:0]  press;
    logic [CNT_W-1:0] db_cnt [NBTN];

    logic             up_ev;
    logic             down_ev;
    logic             load_ev;

    logic [SEL_W-1:0] sel_reg;
    logic [SEL_W-1:0] sel_nxt;

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] prog_reg;
    logic [SEL_W-1:0] prog_nxt;
    logic             update_reg;
    logic             update_nxt;
    logic [PW-1:0]    pcnt;
    logic [PW-1:0]    pcnt_nxt;

    assign raw = {bus.btn_load, bus.btn_down, bus.btn_up};

    // Two-flop synchronizers and per-button debounce counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1       <= '0;
            s2       <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            for (int i = 0; i < NBTN; i++) begin
                if (s2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // One-cycle press events on accepted rising levels; releases are ignored.
    always_comb begin
        press   = stable & ~stable_d;
        up_ev   = press[0];
        down_ev = press[1];
        load_ev = press[2];
    end

    // Saturating selection; simultaneous up and down cancel.
    always_comb begin
        sel_nxt = sel_reg;
        if (up_ev && !down_ev && (sel_reg != SEL_MAX)) begin
            sel_nxt = sel_reg + SEL_W'(1);
        end else if (down_ev && !up_ev && (sel_reg != '0)) begin
            sel_nxt = sel_reg - SEL_W'(1);
        end
    end

    // Load FSM next state: capture sel and hold update for UPDATE_CYCLES cycles.
    always_comb begin
        state_nxt  = state;
        prog_nxt   = prog_reg;
        update_nxt = update_reg;
        pcnt_nxt   = pcnt;
        case (state)
            IDLE: begin
                update_nxt = 1'b0;
                if (load_ev) begin
                    prog_nxt   = sel_reg;
                    update_nxt = 1'b1;
                    pcnt_nxt   = UPD_LAST;
                    state_nxt  = STROBE;
                end
            end
            STROBE: begin
                if (pcnt == '0) begin
                    update_nxt = 1'b0;
                    state_nxt  = IDLE;
                end else begin
                    pcnt_nxt = pcnt - PW'(1);
                end
            end
            default: begin
                update_nxt = 1'b0;
                state_nxt  = IDLE;
            end
        endcase
    end

    // State, selection and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            sel_reg    <= '0;
            prog_reg   <= '0;
            update_reg <= 1'b0;
            pcnt       <= '0;
        end else begin
            state      <= state_nxt;
            sel_reg    <= sel_nxt;
            prog_reg   <= prog_nxt;
            update_reg <= update_nxt;
            pcnt       <= pcnt_nxt;
        end
    end

    assign bus.sel     = sel_reg;
    assign bus.prog_in = prog_reg;
    assign bus.update  = update_reg;
    assign bus.pending = (sel_reg != prog_reg);

endmodule

// File: tb/tb_prog_ctrl.sv
// Bench for prog_ctrl: three instances (UPDATE_CYCLES 1, 3, 12) share one stimulus
// and are checked every cycle against a history-window model plus literal expectations.
module tb_prog_ctrl;
    localparam int unsigned NI = 3;
    localparam int unsigned DB = 4;
    localparam int unsigned UC [NI] = '{1, 3, 12};

    logic clk;
    logic rst;
    logic btn_up;
    logic btn_down;
    logic btn_load;

    logic [NI-1:0][2:0] o_sel;
    logic [NI-1:0][2:0] o_prog;
    logic [NI-1:0]      o_upd;
    logic [NI-1:0]      o_pend;

    int n_vec = 0;
    int n_err = 0;

    // Model state
    bit [15:0] m_hist [3];
    bit [2:0]  m_stab;
    bit [2:0]  m_stab_d;
    int        m_sel;
    int        m_prog [NI];
    int        m_rem  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        prog_ctrl_if bus ();
        assign bus.btn_up   = btn_up;
        assign bus.btn_down = btn_down;
        assign bus.btn_load = btn_load;
        assign o_sel[g]  = bus.sel;
        assign o_prog[g] = bus.prog_in;
        assign o_upd[g]  = bus.update;
        assign o_pend[g] = bus.pending;
        prog_ctrl #(
            .DEBOUNCE_CYCLES(DB),
            .UPDATE_CYCLES  (UC[g])
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: a level is accepted once the last DB synchronized samples
    // (raw delayed by two edges) all disagree with the accepted level.
    always @(posedge clk) begin : p_model
        bit [2:0] raw;
        bit [2:0] ev;
        bit       flip;
        raw = {btn_load, btn_down, btn_up};
        if (!rst) begin
            for (int b = 0; b < 3; b++) m_hist[b] = '0;
            m_stab   = '0;
            m_stab_d = '0;
            m_sel    = 0;
            for (int i = 0; i < NI; i++) begin
                m_prog[i] = 0;
                m_rem[i]  = 0;
            end
        end else begin
            ev = m_stab & ~m_stab_d;
            for (int i = 0; i < NI; i++) begin
                if (m_rem[i] > 0) begin
                    m_rem[i] = m_rem[i] - 1;
                end else if (ev[2]) begin
                    m_rem[i]  = int'(UC[i]);
                    m_prog[i] = m_sel;
                end
            end
            if (ev[0] && !ev[1]) m_sel = (m_sel < 7) ? m_sel + 1 : 7;
            else if (ev[1] && !ev[0]) m_sel = (m_sel > 0) ? m_sel - 1 : 0;
            m_stab_d = m_stab;
            for (int b = 0; b < 3; b++) begin
                m_hist[b] = {m_hist[b][14:0], raw[b]};
                flip = 1'b1;
                for (int k = 2; k < int'(DB) + 2; k++) begin
                    if (m_hist[b][k] == m_stab[b]) flip = 1'b0;
                end
                if (flip) m_stab[b] = ~m_stab[b];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("sel[%0d]", i),     32'(o_sel[i]),  32'(m_sel));
            chk($sformatf("prog_in[%0d]", i), 32'(o_prog[i]), 32'(m_prog[i]));
            chk($sformatf("update[%0d]", i),  32'(o_upd[i]),  32'(m_rem[i] > 0));
            chk($sformatf("pending[%0d]", i), 32'(o_pend[i]), 32'(m_sel != m_prog[i]));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cmp_model();
        end
    endtask

    task automatic press(input logic u, input logic d, input logic l);
        btn_up = u; btn_down = d; btn_load = l;
        tick(8);
        btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
        tick(8);
    endtask

    task automatic lit_all(input string name, input logic [2:0] s, input logic [2:0] p,
                           input logic u, input logic pd);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s_sel[%0d]", name, i),  32'(o_sel[i]),  32'(s));
            chk($sformatf("%s_prog[%0d]", name, i), 32'(o_prog[i]), 32'(p));
            chk($sformatf("%s_upd[%0d]", name, i),  32'(o_upd[i]),  32'(u));
            chk($sformatf("%s_pend[%0d]", name, i), 32'(o_pend[i]), 32'(pd));
        end
    endtask

    initial begin
        rst = 1'b0; btn_up = 1'b1; btn_down = 1'b0; btn_load = 1'b0;

        // Reset with up held: outputs zero, then one press after full debounce
        tick(3);
        lit_all("reset", 3'd0, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(6);
        lit_all("rst_e6", 3'd0, 3'd0, 1'b0, 1'b0);
        tick(1);
        lit_all("rst_e7", 3'd1, 3'd0, 1'b0, 1'b1);

        // Held press gives no further change; release and press again
        tick(10);
        lit_all("held", 3'd1, 3'd0, 1'b0, 1'b1);
        btn_up = 1'b0;
        tick(8);
        btn_up = 1'b1;
        tick(6);
        chk("up2_e6", 32'(o_sel[0]), 32'd1);
        tick(1);
        chk("up2_e7", 32'(o_sel[0]), 32'd2);
        btn_up = 1'b0;
        tick(8);

        // Saturation at both ends
        for (int n = 0; n < 9; n++) press(1'b1, 1'b0, 1'b0);
        lit_all("sat_hi", 3'd7, 3'd0, 1'b0, 1'b1);
        for (int n = 0; n < 9; n++) press(1'b0, 1'b1, 1'b0);
        lit_all("sat_lo", 3'd0, 3'd0, 1'b0, 1'b0);

        // Load with sel=5; a second load event lands at edge 15
        for (int n = 0; n < 5; n++) press(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            btn_load = (e <= 4) || (e >= 9 && e <= 20);
            tick(1);
            case (e)
                6:  lit_all("ld_e6", 3'd5, 3'd0, 1'b0, 1'b1);
                7:  lit_all("ld_e7", 3'd5, 3'd5, 1'b1, 1'b0);
                8:  begin
                        chk("ld_e8_upd1", 32'(o_upd[0]), 32'd0);
                        chk("ld_e8_upd3", 32'(o_upd[1]), 32'd1);
                        chk("ld_e8_pend1", 32'(o_pend[0]), 32'd0);
                    end
                9:  chk("ld_e9_upd3", 32'(o_upd[1]), 32'd1);
                10: begin
                        chk("ld_e10_upd3", 32'(o_upd[1]), 32'd0);
                        chk("ld_e10_upd12", 32'(o_upd[2]), 32'd1);
                    end
                15: begin
                        chk("ld_e15_upd1", 32'(o_upd[0]), 32'd1);
                        chk("ld_e15_upd3", 32'(o_upd[1]), 32'd1);
                    end
                18: chk("ld_e18_upd12", 32'(o_upd[2]), 32'd1);
                19: chk("ld_e19_upd12", 32'(o_upd[2]), 32'd0);
                24: chk("ld_e24_upd12", 32'(o_upd[2]), 32'd0);
                default: ;
            endcase
        end
        lit_all("ld_done", 3'd5, 3'd5, 1'b0, 1'b0);

        // Bounce: high 3, low 1, then high; event four synchronized cycles after last rise
        for (int e = 1; e <= 12; e++) begin
            btn_up = (e <= 3) || (e >= 5);
            tick(1);
            if (e == 10) chk("bnc_e10", 32'(o_sel[0]), 32'd5);
            if (e == 11) chk("bnc_e11", 32'(o_sel[0]), 32'd6);
        end
        btn_up = 1'b0;
        tick(8);
        for (int e = 1; e <= 12; e++) begin
            btn_up = (e <= 3);
            tick(1);
        end
        chk("glitch", 32'(o_sel[0]), 32'd6);

        // Up and down together cancel
        press(1'b1, 1'b1, 1'b0);
        lit_all("updn", 3'd6, 3'd5, 1'b0, 1'b1);

        // Load and up together with sel=2
        for (int n = 0; n < 4; n++) press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b1);
        tick(8);
        lit_all("ld_up", 3'd3, 3'd2, 1'b0, 1'b1);

        // Reset in the middle of a strobe
        btn_load = 1'b1;
        tick(7);
        chk("mid_upd3", 32'(o_upd[1]), 32'd1);
        chk("mid_upd12", 32'(o_upd[2]), 32'd1);
        rst = 1'b0;
        tick(1);
        lit_all("mid_rst", 3'd0, 3'd0, 1'b0, 1'b0);
        btn_load = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(10);
        lit_all("end", 3'd0, 3'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
